// File: rtl/frame_ram_arbiter.sv
// Shares the single frame-RAM port between the LCD refresh reader and the drawing writer.
// Reads win by default; the writer is guaranteed a slot after MAX_STREAK contested reads.
module frame_ram_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 8,
  parameter int RD_LAT     = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   conflict_cnt,
  output logic          busy
);

  logic            grant_rd_s;
  logic            grant_wr_s;
  logic            both_req_s;
  logic [3:0]      streak_r;
  logic [RD_LAT:0] inflight_r;

  assign both_req_s = rd_req & wr_req;
  assign rd_ack     = grant_rd_s;
  assign wr_ack     = grant_wr_s;
  assign rd_valid   = inflight_r[RD_LAT];
  assign rd_data    = ram_rdata;
  assign busy       = |inflight_r;

  // Per-cycle grant decision: reader first unless the writer has waited out its streak.
  always_comb begin
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;
    if (rst) begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
    end else if (both_req_s) begin
      if (streak_r < 4'(MAX_STREAK)) begin
        grant_rd_s = 1'b1;
      end else begin
        grant_wr_s = 1'b1;
      end
    end else if (rd_req) begin
      grant_rd_s = 1'b1;
    end else if (wr_req) begin
      grant_wr_s = 1'b1;
    end else begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
    end
  end

  // Count reads granted while the writer keeps waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_r <= 4'd0;
    end else if (grant_wr_s || !wr_req) begin
      streak_r <= 4'd0;
    end else if (grant_rd_s) begin
      streak_r <= streak_r + 4'd1;
    end else begin
      streak_r <= streak_r;
    end
  end

  // RAM command registers: the winner's address, write data only on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= {AW{1'b0}};
      ram_wdata <= {DW{1'b0}};
      ram_wren  <= 1'b0;
    end else if (grant_wr_s) begin
      ram_addr  <= wr_addr;
      ram_wdata <= wr_data;
      ram_wren  <= 1'b1;
    end else if (grant_rd_s) begin
      ram_addr  <= rd_addr;
      ram_wren  <= 1'b0;
    end else begin
      ram_wren  <= 1'b0;
    end
  end

  // In-flight read pipeline; a reset flushes every outstanding return.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= '0;
    end else begin
      inflight_r <= {inflight_r[RD_LAT-1:0], grant_rd_s};
    end
  end

  // Saturating count of contested cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
    end else if (both_req_s && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end else begin
      conflict_cnt <= conflict_cnt;
    end
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Randomized and directed bench for frame_ram_arbiter against a transaction-level model
// holding a shadow memory and a queue of expected read returns.
module tb_frame_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int RD_LAT = 1;
  localparam int MAX_STREAK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_ack, wr_ack, rd_valid, ram_wren, busy;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   conflict_cnt;

  always #10 clk = ~clk;

  frame_ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt), .busy(busy)
  );

  // Frame RAM with one edge of read latency (returns old data on read-during-write)
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  typedef struct {int due; logic [DW-1:0] data;} rd_ret_t;
  rd_ret_t       ret_q[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            reads_while_wr_waits = 0;
  int            cnt_m = 0;
  logic          exp_wren = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  int            cyc = 0;
  bit            last_rd = 1'b0, last_wr = 1'b0;
  int            n_wr_grants = 0;
  int            checks = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: compare outputs at negedge against the model, advance the model, return at posedge+1
  task automatic step();
    bit g_rd, g_wr, v;
    @(negedge clk);
    g_rd = 1'b0;
    g_wr = 1'b0;
    if (!rst) begin
      if (rd_req && wr_req) begin
        if (reads_while_wr_waits < MAX_STREAK) g_rd = 1'b1;
        else g_wr = 1'b1;
      end else if (rd_req) g_rd = 1'b1;
      else if (wr_req) g_wr = 1'b1;
    end
    check("rd_ack", 32'(rd_ack), 32'(g_rd));
    check("wr_ack", 32'(wr_ack), 32'(g_wr));
    check("ram_wren", 32'(ram_wren), 32'(exp_wren));
    check("ram_addr", 32'(ram_addr), 32'(exp_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
    check("busy", 32'(busy), 32'(ret_q.size() != 0));
    check("conflict_cnt", 32'(conflict_cnt), 32'(cnt_m));
    v = (ret_q.size() != 0) && (ret_q[0].due == cyc);
    check("rd_valid", 32'(rd_valid), 32'(v));
    if (v) begin
      check("rd_data", 32'(rd_data), 32'(ret_q[0].data));
      void'(ret_q.pop_front());
    end
    last_rd = g_rd;
    last_wr = g_wr;
    if (rst) begin
      ret_q.delete();
      reads_while_wr_waits = 0;
      cnt_m = 0;
      exp_wren = 1'b0;
      exp_addr = '0;
      exp_wdata = '0;
    end else begin
      if (rd_req && wr_req && cnt_m < 65535) cnt_m++;
      exp_wren = g_wr;
      if (g_wr) begin
        n_wr_grants++;
        shadow[wr_addr] = wr_data;
        exp_addr = wr_addr;
        exp_wdata = wr_data;
      end else if (g_rd) begin
        exp_addr = rd_addr;
        ret_q.push_back('{due: cyc + 1 + RD_LAT, data: shadow[rd_addr]});
      end
      if (!wr_req || g_wr) reads_while_wr_waits = 0;
      else if (g_rd) reads_while_wr_waits++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base_wr;
    for (int a = 0; a < (1 << AW); a++) begin
      ram[a] = DW'(a * 7 + 3);
      shadow[a] = DW'(a * 7 + 3);
    end
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    @(posedge clk);
    #1;

    // Reset held 3 cycles with both requesters active; reader wins after release
    rd_req = 1'b1; wr_req = 1'b1;
    repeat (3) step();
    check("rst_no_wren", 32'(ram_wren), 32'd0);
    rst = 1'b0;
    step();
    check("first_grant_reader", 32'(last_rd), 32'd1);
    rd_req = 1'b0; wr_req = 1'b0;
    step();

    // Full contention for 20 cycles straight after a reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1;
    base_wr = n_wr_grants;
    for (int k = 0; k < 20; k++) begin
      step();
      check("contend_pattern", 32'(last_wr), 32'(k % 5 == 4));
    end
    check("contend_cnt", 32'(conflict_cnt), 32'd20);
    check("contend_writes", 32'(n_wr_grants - base_wr), 32'd4);
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) step();

    // Single read of a preloaded byte
    ram[10'h155] = 8'h3C;
    shadow[10'h155] = 8'h3C;
    rd_req = 1'b1; rd_addr = 10'h155;
    step();
    rd_req = 1'b0;
    step();
    check("single_rd_valid", 32'(rd_valid), 32'd1);
    check("single_rd_data", 32'(rd_data), 32'h3C);
    step();

    // Single write then read-back
    wr_req = 1'b1; wr_addr = 10'h2A0; wr_data = 8'hA5;
    step();
    wr_req = 1'b0;
    step();
    rd_req = 1'b1; rd_addr = 10'h2A0;
    step();
    rd_req = 1'b0;
    step();
    check("wr_readback", 32'(rd_data), 32'hA5);
    repeat (2) step();

    // Back-to-back reads 0..7
    for (int a = 0; a < 8; a++) begin
      rd_req = 1'b1; rd_addr = AW'(a);
      step();
    end
    rd_req = 1'b0;
    repeat (RD_LAT + 2) step();

    // Reset in the cycle after three read grants
    for (int a = 0; a < 3; a++) begin
      rd_req = 1'b1; rd_addr = AW'(a + 40);
      step();
    end
    rd_req = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    repeat (3) step();

    // Random traffic honouring hold-until-ack, with occasional cancels and resets
    for (int i = 0; i < 3000; i++) begin
      if (rd_req && !last_rd) begin
        if ($urandom_range(15) == 0) rd_req = 1'b0;
      end else begin
        rd_req = 1'($urandom_range(1));
        rd_addr = AW'($urandom);
      end
      if (wr_req && !last_wr) begin
        if ($urandom_range(15) == 0) wr_req = 1'b0;
      end else begin
        wr_req = 1'($urandom_range(1));
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom);
      end
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;

    // Sustained contention long enough to saturate the conflict counter
    rd_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      if (last_rd) rd_addr = AW'($urandom);
      if (last_wr) begin
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom);
      end
      step();
    end
    check("cnt_saturated", 32'(conflict_cnt), 32'hFFFF);
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
